serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request to subtract; sampled only when busy=0.
REQ-005 SHALL provide port: a  input  WIDTH  minuend; sampled with start.
REQ-006 SHALL provide port: b  input  WIDTH  subtrahend; sampled with start.
REQ-007 SHALL provide port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 SHALL provide port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL provide port: diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL provide port: borrow_out  output  1  borrow out of MSB (unsigned a<b).
REQ-011 SHALL provide port: ovf  output  1  two's-complement overflow of a-b.

Function
REQ-012 SHALL implement a bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop, LSB first, one bit per clock.
REQ-013 SHALL, per bit i: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-014 SHALL use FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1 at edge k: load a and b into shift registers, clear borrow flip-flop, clear bit counter, go to RUN; busy=1 after edge k.
REQ-016 SHALL, in IDLE with start=0: remain in IDLE, shift registers unchanged.
REQ-017 SHALL, in RUN: process one bit per edge (edges k+1..k+WIDTH), shift the result bit into the MSB of a result shift register, increment the counter.
REQ-018 SHALL, on the edge processing bit WIDTH-1: go to DONE, copy the assembled result to diff, the final borrow to borrow_out, and (borrow into MSB XOR borrow out of MSB) to ovf.
REQ-019 SHALL, in DONE: drive done=1 for exactly one cycle, then go to IDLE at the next edge (busy=0 after edge k+WIDTH+1).
REQ-020 SHALL give latency: done high in the cycle following edge k+WIDTH, i.e. WIDTH cycles after the start-sampling edge.
REQ-021 SHALL hold diff, borrow_out and ovf stable from entry into DONE until the next operation's DONE entry; they SHALL NOT show partial results during RUN.
REQ-022 SHALL ignore start while busy=1 (RUN or DONE), with no effect on state, operands or result.
REQ-023 SHALL accept start in the cycle after done (first IDLE cycle), giving back-to-back throughput of one operation per WIDTH+2 cycles.
REQ-024 SHALL use a bit counter of ceil(log2(WIDTH)) bits or wider; it SHALL NOT wrap before the DONE transition.
REQ-025 SHALL treat changes of a and b after the start-sampling edge as having no effect.

Reset
REQ-026 SHALL, when rst_n=0, immediately and asynchronously force state=IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf=0, and clear the counter, borrow and shift registers.
REQ-027 SHALL, on reset asserted mid-operation (RUN or DONE), abort the operation; no done pulse is produced for it.
REQ-028 SHALL, after rst_n deasserts, leave start ignored until the first rising edge with rst_n=1; the block is then in IDLE and ready.

Verification
REQ-029 SHALL cover, WIDTH=8: a=0x05, b=0x03, start at edge k -> done pulse after edge k+8, diff=0x02, borrow_out=0, ovf=0.
REQ-030 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, ovf=0.
REQ-031 SHALL cover: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1; also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
REQ-032 SHALL cover: start=1 held continuously with a/b changing every cycle -> only the values at the IDLE edges are used; results arrive every 10 cycles, matching those values.
REQ-033 SHALL cover: rst_n pulsed low at cycle k+4 of an operation -> all outputs 0 immediately, no done; next op a=0x00, b=0x00 -> diff=0x00, borrow_out=0, ovf=0.
REQ-034 SHALL cover: random a/b for 1000 ops at WIDTH=8 and WIDTH=2 -> {borrow_out,diff} equals (a-b) mod 2^(WIDTH+1) reference, ovf equals signed-overflow reference.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial subtractor (a - b), LSB first, one bit per clock.
//
// A single full-subtractor cell and a borrow flip-flop walk both operands
// out of their shift registers. Result bits are shifted into the MSB of a
// result register, so after WIDTH bits the word is in place.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request; sampled only while idle (busy=0)
//   a, b        minuend / subtrahend, captured on the start edge
//   busy        high in RUN and DONE
//   done        one-cycle pulse, result outputs valid
//   diff        a - b modulo 2^WIDTH
//   borrow_out  borrow out of the MSB (unsigned a < b)
//   ovf         two's-complement overflow of a - b
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  // One extra count value so the counter never wraps while running.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;

  logic             a_bit, b_bit, d_bit, br_next;

  // Full-subtractor cell on the current LSBs.
  assign a_bit   = a_q[0];
  assign b_bit   = b_q[0];
  assign d_bit   = a_bit ^ b_bit ^ br_q;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Publish the whole word at once; outputs never show partial bits.
          // At the MSB, br_q is the borrow in and br_next the borrow out.
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bo_d    = br_next;
          ovf_d   = br_q ^ br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub -- directed and randomised checks of serial_sub at
// WIDTH=8 and WIDTH=2 (two instances sharing clock and reset).
module tb_serial_sub;

  logic       clk;
  logic       rst_n;

  logic       start8, busy8, done8, bo8, ovf8;
  logic [7:0] a8, b8, diff8;

  logic       start2, busy2, done2, bo2, ovf2;
  logic [1:0] a2, b2, diff2;

  int vectors;
  int miscompares;

  logic [7:0] prev8;
  logic [1:0] prev2;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Runs one WIDTH=8 operation starting at the next rising edge.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ediff, input logic ebo, input logic eovf,
                     input string tag);
    int n;
    n = 0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv;            // later operand changes must not matter
    check({tag, "_busy"}, busy8, 1);
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (i == 4) check({tag, "_hold"}, diff8, prev8);
      if (done8) n = i;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_diff"}, diff8, ediff);
    check({tag, "_bo"}, bo8, ebo);
    check({tag, "_ovf"}, ovf8, eovf);
    prev8 = ediff;
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy8, done8}, 2'b00);
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv,
                     input logic [1:0] ediff, input logic ebo, input logic eovf,
                     input string tag);
    int n;
    n = 0;
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    a2 = ~av; b2 = ~bv;
    check({tag, "_busy"}, busy2, 1);
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (i == 1) check({tag, "_hold"}, diff2, prev2);
      if (done2) n = i;
    end
    check({tag, "_lat"}, n, 2);
    check({tag, "_diff"}, diff2, ediff);
    check({tag, "_bo"}, bo2, ebo);
    check({tag, "_ovf"}, ovf2, eovf);
    prev2 = ediff;
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy2, done2}, 2'b00);
  endtask

  initial begin
    logic [7:0] va [30];
    logic [7:0] vb [30];
    logic [8:0] r9;
    logic [2:0] r3;
    logic [7:0] ra, rb;
    logic [1:0] sa, sb;
    int         nd;

    vectors = 0; miscompares = 0;
    prev8 = '0; prev2 = '0;
    start8 = 0; a8 = '0; b8 = '0;
    start2 = 0; a2 = '0; b2 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_outs8", {busy8, done8, diff8, bo8, ovf8}, 12'h000);
    check("rst_outs2", {busy2, done2, diff2, bo2, ovf2}, 6'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed WIDTH=8 cases, issued back to back.
    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "d05m03");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "d03m05");
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "d80m01");
    op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "d7FmFF");

    // start held high with operands changing every cycle: captures at
    // cycles 0, 10, 20; results visible after edges 8, 18, 28.
    for (int c = 0; c < 30; c++) begin
      va[c] = 8'(c * 37 + 11);
      vb[c] = 8'(c * 91 + 5);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a8 = va[c]; b8 = vb[c]; start8 = 1'b1;
      @(posedge clk); #1;
      if (c % 10 == 8) begin
        r9 = {1'b0, va[c-8]} - {1'b0, vb[c-8]};
        check("cont_done", done8, 1);
        check("cont_res", {bo8, diff8}, r9);
      end else begin
        check("cont_nodone", done8, 0);
      end
    end
    start8 = 1'b0;
    prev8 = 8'(va[20] - vb[20]);

    // Reset in the middle of an operation.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {busy8, done8, diff8, bo8, ovf8}, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    check("midrst_nodone", nd, 0);
    prev8 = '0;
    op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "d00m00");

    // Directed WIDTH=2 cases.
    prev2 = '0;
    op2(2'b01, 2'b10, 2'b11, 1'b1, 1'b1, "w2_1m2");
    op2(2'b00, 2'b01, 2'b11, 1'b1, 1'b0, "w2_0m1");

    // Random operations against an arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      r9 = {1'b0, ra} - {1'b0, rb};
      op8(ra, rb, r9[7:0], r9[8], (ra[7] ^ rb[7]) & (r9[7] ^ ra[7]), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      sa = 2'($urandom); sb = 2'($urandom);
      r3 = {1'b0, sa} - {1'b0, sb};
      op2(sa, sb, r3[1:0], r3[2], (sa[1] ^ sb[1]) & (r3[1] ^ sa[1]), "rnd2");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
